// File: rtl/ysyx_23060332_ifu.sv
// Instruction fetch: one outstanding imem request; the instruction is held for decode 1 cycle after rvalid (3 cycles/instr minimum).
// Holds in HOLD until id_ready; redirects squash in-flight data. IFU_MISALIGN_CHK_EN: a misaligned redirect faults and halts.
module ysyx_23060332_ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst_o,
  output logic [31:0] inst_addr_o,
  input  logic        id_ready,
  input  logic        jump_en,
  input  logic [31:0] jump_addr,
  output logic        fault_o
);

  typedef enum logic [1:0] {FETCH, WAIT, HOLD, HALT} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic        discard, discard_nxt;
  logic        load_inst;
  logic        fetch_go;
  logic        jump_bad;
  logic [31:0] jump_tgt;

  assign jump_tgt = jump_addr & 32'hFFFF_FFFC;

`ifdef IFU_MISALIGN_CHK_EN
  logic fault_q;

  assign jump_bad = jump_en && (jump_addr[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (rst) begin
      fault_q <= 1'b0;
    end else if (jump_bad && state != HALT) begin
      fault_q <= 1'b1;
    end
  end

  assign fault_o = fault_q;
`else
  assign jump_bad = 1'b0;
  assign fault_o  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      discard     <= 1'b0;
      inst_o      <= 32'h0000_0013;
      inst_addr_o <= 32'h0000_0000;
    end else begin
      state   <= state_nxt;
      pc      <= pc_nxt;
      discard <= discard_nxt;
      if (load_inst) begin
        inst_o      <= imem_rdata;
        inst_addr_o <= pc;
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc;
    discard_nxt = discard;
    load_inst   = 1'b0;
    fetch_go    = 1'b0;
    case (state)
      FETCH: begin
        if (jump_bad) begin
          state_nxt = HALT;
        end else if (jump_en) begin
          pc_nxt = jump_tgt;
        end else begin
          fetch_go  = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (jump_bad) begin
          state_nxt = HALT;
        end else if (jump_en) begin
          pc_nxt = jump_tgt;
          // A response arriving with the redirect is the stale one; nothing left to discard.
          if (imem_rvalid) begin
            discard_nxt = 1'b0;
            state_nxt   = FETCH;
          end else begin
            discard_nxt = 1'b1;
          end
        end else if (imem_rvalid) begin
          if (discard) begin
            discard_nxt = 1'b0;
            state_nxt   = FETCH;
          end else begin
            load_inst = 1'b1;
            state_nxt = HOLD;
          end
        end
      end
      HOLD: begin
        if (jump_bad) begin
          state_nxt = HALT;
        end else if (jump_en) begin
          pc_nxt    = jump_tgt;
          state_nxt = FETCH;
        end else if (id_ready) begin
          pc_nxt    = pc + 32'd4;
          state_nxt = FETCH;
        end
      end
      HALT: begin
        state_nxt = HALT;
      end
      default: begin
        state_nxt = FETCH;
      end
    endcase
  end

  assign imem_req   = fetch_go & ~rst;
  assign imem_addr  = rst ? RESET_PC : pc;
  assign inst_valid = (state == HOLD) & ~rst;

endmodule

// File: doc/ysyx_23060332_ifu.md
YSYX_23060332_IFU -- requirements
Module: ysyx_23060332_ifu

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h8000_0000, the first fetch address after reset.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, the reset; it is synchronous and active-high.
REQ-004 SHALL have port imem_req, output, 1, a fetch request to instruction memory, valid for one cycle.
REQ-005 SHALL have port imem_addr, output, 32, the fetch address, qualified by imem_req.
REQ-006 SHALL have port imem_rvalid, input, 1, meaning instruction memory returns data this cycle.
REQ-007 SHALL have port imem_rdata, input, 32, the returned instruction word, qualified by imem_rvalid.
REQ-008 SHALL have port inst_valid, output, 1, meaning the decode stage has a valid instruction.
REQ-009 SHALL have port inst_o, output, 32, the instruction word driven to the decoder's inst_i.
REQ-010 SHALL have port inst_addr_o, output, 32, the PC of inst_o, driven to the decoder's inst_addr.
REQ-011 SHALL have port id_ready, input, 1, meaning the decoder consumes inst_o this cycle.
REQ-012 SHALL have port jump_en, input, 1, a redirect request from EXU.
REQ-013 SHALL have port jump_addr, input, 32, the redirect target.
REQ-014 SHALL have port fault_o, output, 1, a sticky misaligned-target fault.

Function
REQ-015 SHALL implement states FETCH, WAIT, HOLD and HALT, plus a 32-bit PC register and a one-bit discard flag.
REQ-016 FETCH with no jump_en: SHALL assert imem_req with imem_addr = PC, then go to WAIT.
REQ-017 WAIT on imem_rvalid with discard clear: SHALL register imem_rdata into inst_o and PC into inst_addr_o, then go to HOLD.
REQ-018 SHALL assert inst_valid only in HOLD; memory-to-decoder latency is exactly 1 cycle after imem_rvalid, and the minimum is 3 cycles per instruction.
REQ-019 HOLD: inst_o and inst_addr_o SHALL stay stable until id_ready; on id_ready with no jump_en, PC becomes PC+4 (32-bit wrap) and the state returns to FETCH.
REQ-020 jump_en in FETCH: PC becomes jump_addr, no imem_req that cycle, and the state stays FETCH.
REQ-021 jump_en in WAIT: PC becomes jump_addr and discard is set; if imem_rvalid is high the same cycle, that data SHALL be dropped.
REQ-022 WAIT with discard set: the next imem_rvalid data SHALL be dropped, discard cleared, and the state returns to FETCH.
REQ-023 jump_en in HOLD, with or without id_ready: the held instruction is not delivered, inst_valid drops the next cycle, PC becomes jump_addr, and the state goes to FETCH.
REQ-024 SHALL never have more than one outstanding imem request.
REQ-025 HALT: no imem_req, inst_valid=0, and the state is held until rst.

Reset
REQ-026 rst SHALL override every other input in the same cycle.
REQ-027 Reset values: PC=RESET_PC, state=FETCH, discard=0, imem_req=0, imem_addr=RESET_PC, inst_valid=0, inst_o=32'h0000_0013 (NOP), inst_addr_o=0, fault_o=0.
REQ-028 Reset during WAIT SHALL discard the outstanding response; an imem_rvalid arriving after reset, before any new request, SHALL be ignored.

Configuration
REQ-029 Macro IFU_MISALIGN_CHK_EN defined: jump_en with jump_addr[1:0]!=0 SHALL set fault_o (sticky) and enter HALT, overriding REQ-020 to REQ-023.
REQ-030 Macro IFU_MISALIGN_CHK_EN undefined: jump_addr[1:0] SHALL be forced to 0 when loaded into PC, fault_o tied 0, and HALT unreachable.

Verification
REQ-031 Release rst, memory answers 1 cycle after each request, id_ready always 1 -> imem_addr sequence 0x80000000, 0x80000004, 0x80000008; inst_valid one cycle in three.
REQ-032 Hold id_ready=0 for 5 cycles in HOLD -> inst_o/inst_addr_o stable, no new imem_req; id_ready=1 -> next request at PC+4.
REQ-033 jump_en with jump_addr=0x80000100 in WAIT, rvalid 2 cycles later with 0x00100073 -> data dropped, inst_valid stays 0, next imem_addr=0x80000100.
REQ-034 jump_en together with id_ready in HOLD, jump_addr=0x80000040 -> inst_valid 0 next cycle, next imem_addr=0x80000040.
REQ-035 With IFU_MISALIGN_CHK_EN, jump_addr=0x80000102 -> fault_o=1, no further imem_req until rst; without the macro -> next imem_addr=0x80000100.
